axis_pkt_gen: RTL and testbench

AXI-Stream packet transmitter that drives the slave port (`s_data`/`s_valid`/`s_last`, honouring `s_ready`) of the team's 4096-deep stream FIFO. Under software-style control it emits a programmed number of fixed-length packets of deterministic, incrementing payload, with an optional idle gap between packets. It is the stimulus source for FIFO bring-up on the board and for throughput/backpressure regression.

---
 rtl/axis_pkt_gen_if.sv | 28 ++
 rtl/axis_pkt_gen.sv | 153 +++++++++++++++
 tb/tb_axis_pkt_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream master/slave bundle between the packet generator and its sink.
// Signals:
//   m_data  : stream payload, driven by the master
//   m_valid : payload valid, driven by the master
//   m_last  : final word of a packet, driven by the master
//   m_ready : sink can accept, driven by the slave
interface axis_pkt_gen_if #(
    parameter int unsigned data_width = 32
) ();
    logic [data_width-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits num_pkts packets of pkt_len words with
// an incrementing payload starting at seed, and gap idle cycles between
// packets.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, stop     : begin a run (IDLE only) / end the run after the current packet
//   pkt_len         : words per packet (latched on start)
//   num_pkts        : packets per run (latched on start)
//   gap             : idle cycles between packets (latched on start)
//   seed            : payload of the first word of a run (latched on start)
//   axis            : stream master (m_data, m_valid, m_last out; m_ready in)
//   busy            : high whenever a run is in progress
//   done            : one-cycle pulse when a run ends
//   pkt_cnt         : packets fully transferred in the current/last run
module axis_pkt_gen #(
    parameter int unsigned data_width = 32,
    parameter int unsigned Len_width  = 13,
    parameter int unsigned Cnt_width  = 16,
    parameter int unsigned Gap_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [Len_width-1:0]  pkt_len,
    input  logic [Cnt_width-1:0]  num_pkts,
    input  logic [Gap_width-1:0]  gap,
    input  logic [data_width-1:0] seed,
    axis_pkt_gen_if.master        axis,
    output logic                  busy,
    output logic                  done,
    output logic [Cnt_width-1:0]  pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state;
    logic [Len_width-1:0] len_q;
    logic [Cnt_width-1:0] num_q;
    logic [Gap_width-1:0] gap_q;
    logic [Gap_width-1:0] gap_cnt;
    logic [Len_width-1:0] word_idx;
    logic                 stop_pend;

    // Decodes of latched configuration and live control.
    logic first_last;
    logic next_is_last;
    logic last_pkt;
    logic stop_any;

    assign first_last   = (len_q == Len_width'(1));
    assign next_is_last = ((word_idx + Len_width'(1)) == (len_q - Len_width'(1)));
    assign last_pkt     = ((pkt_cnt + Cnt_width'(1)) == num_q);
    // A stop arriving on the deciding edge counts the same as one already pending.
    assign stop_any     = stop_pend | stop;

    // Control FSM; m_data doubles as the running payload counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            num_q        <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            word_idx     <= '0;
            stop_pend    <= 1'b0;
            axis.m_data  <= '0;
            axis.m_valid <= 1'b0;
            axis.m_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && stop) begin
                stop_pend <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start && pkt_len != '0 && num_pkts != '0) begin
                        state       <= ST_SEND;
                        busy        <= 1'b1;
                        len_q       <= pkt_len;
                        num_q       <= num_pkts;
                        gap_q       <= gap;
                        axis.m_data <= seed;
                        pkt_cnt     <= '0;
                        word_idx    <= '0;
                        stop_pend   <= 1'b0;
                    end
                end

                ST_SEND: begin
                    if (!axis.m_valid) begin
                        // First word of a run: payload was loaded on the start edge.
                        axis.m_valid <= 1'b1;
                        axis.m_last  <= first_last;
                    end else if (axis.m_ready) begin
                        axis.m_data <= axis.m_data + data_width'(1);
                        if (!axis.m_last) begin
                            word_idx    <= word_idx + Len_width'(1);
                            axis.m_last <= next_is_last;
                        end else begin
                            pkt_cnt  <= pkt_cnt + Cnt_width'(1);
                            word_idx <= '0;
                            if (last_pkt || stop_any) begin
                                state        <= ST_IDLE;
                                axis.m_valid <= 1'b0;
                                axis.m_last  <= 1'b0;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                                stop_pend    <= 1'b0;
                            end else if (gap_q != '0) begin
                                state        <= ST_GAP;
                                gap_cnt      <= gap_q;
                                axis.m_valid <= 1'b0;
                                axis.m_last  <= 1'b0;
                            end else begin
                                // Back-to-back: next packet's first word follows immediately.
                                axis.m_last <= first_last;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (stop_any) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                    end else if (gap_cnt == Gap_width'(1)) begin
                        state        <= ST_SEND;
                        axis.m_valid <= 1'b1;
                        axis.m_last  <= first_last;
                    end else begin
                        gap_cnt <= gap_cnt - Gap_width'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: table of runs plus hand-written corner cases.
module tb_axis_pkt_gen;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 13;
    localparam int unsigned CW = 16;
    localparam int unsigned GW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [LW-1:0] pkt_len;
    logic [CW-1:0] num_pkts;
    logic [GW-1:0] gap;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_cnt;

    axis_pkt_gen_if #(.data_width(DW)) axis ();

    axis_pkt_gen #(
        .data_width(DW),
        .Len_width (LW),
        .Cnt_width (CW),
        .Gap_width (GW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pkt_len (pkt_len),
        .num_pkts(num_pkts),
        .gap     (gap),
        .seed    (seed),
        .axis    (axis),
        .busy    (busy),
        .done    (done),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          len;
        int          num;
        int          gap;
        logic [31:0] seed;
        bit          rand_ready;
        int          stop_at;     // transfer index at which stop is pulsed (-1: never)
        int          restart_at;  // transfer index at which a stray start is pulsed
        int          exp_words;
        int          exp_cnt;
        logic [31:0] exp_final;
    } vec_t;

    // Starts a run at the current negedge and checks every word until done.
    task automatic run_vec(input vec_t v, input string tag);
        int          idx        = 0;
        int          bubbles    = 0;
        int          cyc        = 0;
        bit          in_gap     = 0;
        bit          early_done = 0;
        bit          stop_sent  = 0;
        bit          rs_sent    = 0;
        bit          finished   = 0;
        logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, r;
        logic [31:0] pd = '0, last_data = '0;

        pkt_len     = LW'(v.len);
        num_pkts    = CW'(v.num);
        gap         = GW'(v.gap);
        seed        = v.seed;
        start       = 1'b1;
        axis.m_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_at_start"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_latency_valid"}, 32'(axis.m_valid), 32'd0);

        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            stop  = 1'b0;
            start = 1'b0;
            if (idx == v.exp_words) begin
                finished = 1;
                break;
            end
            if (done) early_done = 1;
            if (pv && !pr) begin
                check({tag, "_stall_valid"}, 32'(axis.m_valid), 32'd1);
                check({tag, "_stall_data"}, axis.m_data, pd);
                check({tag, "_stall_last"}, 32'(axis.m_last), 32'(pl));
            end
            if (in_gap) begin
                if (!axis.m_valid) bubbles++;
                else begin
                    check({tag, "_gap_bubbles"}, 32'(bubbles), 32'(v.gap));
                    in_gap  = 0;
                    bubbles = 0;
                end
            end
            if (!stop_sent && v.stop_at >= 0 && idx == v.stop_at) begin
                stop      = 1'b1;
                stop_sent = 1;
            end
            if (!rs_sent && v.restart_at >= 0 && idx == v.restart_at) begin
                start   = 1'b1;
                seed    = ~v.seed;
                rs_sent = 1;
            end
            r = v.rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            axis.m_ready = r;
            if (axis.m_valid && r) begin
                check({tag, "_data"}, axis.m_data, v.seed + 32'(idx));
                check({tag, "_last"}, 32'(axis.m_last), 32'((idx % v.len) == v.len - 1));
                last_data = axis.m_data;
                idx++;
                if (axis.m_last && idx != v.exp_words) in_gap = 1;
            end
            pv = axis.m_valid;
            pr = r;
            pd = axis.m_data;
            pl = axis.m_last;
        end

        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d words, expected %0d", tag, idx, v.exp_words);
        end else begin
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_busy_end"}, 32'(busy), 32'd0);
            check({tag, "_valid_end"}, 32'(axis.m_valid), 32'd0);
            check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(v.exp_cnt));
            check({tag, "_final_data"}, last_data, v.exp_final);
            check({tag, "_no_early_done"}, 32'(early_done), 32'd0);
        end
    endtask

    vec_t vecs[7];
    bit   found;

    initial begin
        vecs[0] = '{4,    2,   0, 32'h0000_0010, 1'b0, -1, -1, 8,    2, 32'h0000_0017};
        vecs[1] = '{3,    3,   5, 32'h0000_0100, 1'b0, -1,  4, 9,    3, 32'h0000_0108};
        vecs[2] = '{4096, 1,   0, 32'hA000_0000, 1'b1, -1, -1, 4096, 1, 32'hA000_0FFF};
        vecs[3] = '{10,   100, 0, 32'h0000_0000, 1'b0, 12, -1, 20,   2, 32'h0000_0013};
        vecs[4] = '{1,    5,   2, 32'h0000_0007, 1'b1, -1, -1, 5,    5, 32'h0000_000B};
        vecs[5] = '{3,    1,   0, 32'hFFFF_FFFE, 1'b0, -1, -1, 3,    1, 32'h0000_0000};
        vecs[6] = '{5,    4,   1, 32'h0000_1234, 1'b1,  6, -1, 10,   2, 32'h0000_123D};

        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        pkt_len      = '0;
        num_pkts     = '0;
        gap          = '0;
        seed         = '0;
        axis.m_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_data", axis.m_data, 32'h0);
        check("rst_valid", 32'(axis.m_valid), 32'd0);
        check("rst_last", 32'(axis.m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst = 1'b0;

        // Zero packet count or zero length: start must be ignored.
        @(negedge clk);
        pkt_len  = 13'd4;
        num_pkts = 16'd0;
        start    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("np0_busy", 32'(busy), 32'd0);
            check("np0_valid", 32'(axis.m_valid), 32'd0);
            check("np0_done", 32'(done), 32'd0);
        end
        pkt_len  = 13'd0;
        num_pkts = 16'd3;
        repeat (2) begin
            @(negedge clk);
            check("len0_busy", 32'(busy), 32'd0);
            check("len0_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);

        // Each run starts on the done cycle of the previous one.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stop asserted while idling between packets ends the run immediately.
        pkt_len      = 13'd2;
        num_pkts     = 16'd5;
        gap          = 8'd6;
        seed         = 32'h40;
        axis.m_ready = 1'b1;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axis.m_valid && axis.m_last) begin
                found = 1;
                break;
            end
        end
        check("gs_last_seen", 32'(found), 32'd1);
        check("gs_last_data", axis.m_data, 32'h41);
        @(negedge clk);
        check("gs_in_gap", 32'(axis.m_valid), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("gs_done", 32'(done), 32'd1);
        check("gs_busy", 32'(busy), 32'd0);
        check("gs_pkt_cnt", 32'(pkt_cnt), 32'd1);
        @(negedge clk);
        check("gs_done_pulse", 32'(done), 32'd0);

        // Reset in the middle of packet 1, word 5.
        pkt_len  = 13'd10;
        num_pkts = 16'd3;
        gap      = 8'd0;
        seed     = 32'h50;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axis.m_valid && axis.m_data == 32'h54) begin
                found = 1;
                break;
            end
        end
        check("mr_word5_seen", 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(axis.m_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("mr_data", axis.m_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{2, 1, 0, 32'h0000_0900, 1'b0, -1, -1, 2, 1, 32'h0000_0901}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
